// File: rtl/counter_seq_pkg.sv
// Shared definitions for the counter sequencer.
//   state_t : controller states (IDLE, RUN, HOLD, DONE)
//   OP_*    : command op codes carried on cmd_op
package counter_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_HOLD = 2'b10,
        ST_DONE = 2'b11
    } state_t;

    localparam logic [1:0] OP_START = 2'b00;
    localparam logic [1:0] OP_STOP  = 2'b01;
    localparam logic [1:0] OP_LOAD  = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

endpackage

// File: rtl/counter_prescaler.sv
// Prescaler for the counter sequencer.
// Issues one tick every prescale+1 enabled cycles.
//   CLK, RST_N : clock, synchronous active-low reset
//   en         : advance the prescaler this cycle
//   clr        : return the prescaler to 0 (overrides en)
//   prescale   : terminal value of the prescaler
//   tick       : combinational, high in the enabled cycle the prescaler wraps
module counter_prescaler #(
    parameter int PRESCALE_W = 8
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  en,
    input  logic                  clr,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic                  tick
);

    logic [PRESCALE_W-1:0] presc;

    assign tick = en && (presc == prescale);

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            presc <= '0;
        end else if (clr) begin
            presc <= '0;
        end else if (en) begin
            if (presc == prescale) begin
                presc <= '0;
            end else begin
                presc <= presc + PRESCALE_W'(1);
            end
        end
    end

endmodule

// File: rtl/counter_sequencer.sv
// Counter sequencer: START/STOP/LOAD/CLEAR control of an up-counter with a
// prescaler, terminal-count limit and periodic or one-shot operation.
//   CLK, RST_N       : clock, synchronous active-low reset
//   cmd_EN/RDY       : command strobe / always ready
//   cmd_op, cmd_arg  : command op code and LOAD value
//   cfg_EN/RDY       : configuration write strobe / ready in IDLE or DONE
//   cfg_limit        : terminal count
//   cfg_prescale     : tick every cfg_prescale+1 RUN cycles
//   cfg_oneshot      : 1 = stop at limit, 0 = wrap to 0
//   count_value_*    : read port, RV is the count register
//   tc_pulse         : one-cycle pulse when the limit is reached
//   busy             : high in RUN or HOLD
module counter_sequencer
    import counter_seq_pkg::*;
#(
    parameter int WIDTH      = 4,
    parameter int PRESCALE_W = 8
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  cmd_EN,
    output logic                  cmd_RDY,
    input  logic [1:0]            cmd_op,
    input  logic [WIDTH-1:0]      cmd_arg,
    input  logic                  cfg_EN,
    output logic                  cfg_RDY,
    input  logic [WIDTH-1:0]      cfg_limit,
    input  logic [PRESCALE_W-1:0] cfg_prescale,
    input  logic                  cfg_oneshot,
    output logic                  count_value_RDY,
    input  logic                  count_value_EN,
    output logic [WIDTH-1:0]      count_value_RV,
    output logic                  tc_pulse,
    output logic                  busy
);

    state_t                state;
    logic [WIDTH-1:0]      count;
    logic [WIDTH-1:0]      limit;
    logic [PRESCALE_W-1:0] prescale;
    logic                  oneshot;

    logic tick;
    logic presc_en;
    logic presc_clr;
    logic cmd_override;

    // The read strobe has no side effect; it is sunk here.
    logic unused;
    assign unused = count_value_EN;

    assign cmd_RDY         = 1'b1;
    assign count_value_RDY = 1'b1;
    assign count_value_RV  = count;
    assign cfg_RDY         = (state == ST_IDLE) || (state == ST_DONE);
    assign busy            = (state == ST_RUN) || (state == ST_HOLD);

    // Any command other than START takes priority over a tick in the same
    // cycle, so the prescaler is frozen for that cycle as well.
    assign cmd_override = cmd_EN && (cmd_op != OP_START);
    assign presc_en     = (state == ST_RUN) && !cmd_override;
    assign presc_clr    = cmd_EN && ((cmd_op == OP_LOAD) || (cmd_op == OP_CLEAR) ||
                                     ((cmd_op == OP_START) && (state == ST_DONE)));

    counter_prescaler #(
        .PRESCALE_W (PRESCALE_W)
    ) u_prescaler (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .en       (presc_en),
        .clr      (presc_clr),
        .prescale (prescale),
        .tick     (tick)
    );

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state    <= ST_IDLE;
            count    <= '0;
            limit    <= '1;
            prescale <= '0;
            oneshot  <= 1'b0;
            tc_pulse <= 1'b0;
        end else begin
            tc_pulse <= 1'b0;

            if (cfg_EN && cfg_RDY) begin
                limit    <= cfg_limit;
                prescale <= cfg_prescale;
                oneshot  <= cfg_oneshot;
            end

            if (cmd_EN) begin
                case (cmd_op)
                    OP_START: begin
                        if (state == ST_DONE) begin
                            count <= '0;
                        end
                        state <= ST_RUN;
                    end
                    OP_STOP: begin
                        if (state == ST_RUN) begin
                            state <= ST_HOLD;
                        end
                    end
                    OP_LOAD: begin
                        count <= cmd_arg;
                        if (state == ST_DONE) begin
                            state <= ST_IDLE;
                        end
                    end
                    OP_CLEAR: begin
                        count <= '0;
                        state <= ST_IDLE;
                    end
                endcase
            end

            // tick is only ever high in RUN without an overriding command
            if (tick) begin
                if (count == limit) begin
                    tc_pulse <= 1'b1;
                    if (oneshot) begin
                        state <= ST_DONE;
                    end else begin
                        count <= '0;
                    end
                end else begin
                    count <= count + WIDTH'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_counter_sequencer.sv
// Self-checking bench for counter_sequencer: a cycle-level behavioural model
// checked against the DUT every cycle, plus directed literal expectations.
module tb_counter_sequencer;

    localparam int WIDTH      = 4;
    localparam int PRESCALE_W = 8;
    localparam int MODV       = 1 << WIDTH;

    localparam int S_IDLE = 0;
    localparam int S_RUN  = 1;
    localparam int S_HOLD = 2;
    localparam int S_DONE = 3;

    localparam logic [1:0] C_START = 2'b00;
    localparam logic [1:0] C_STOP  = 2'b01;
    localparam logic [1:0] C_LOAD  = 2'b10;
    localparam logic [1:0] C_CLEAR = 2'b11;

    logic                  CLK = 1'b0;
    logic                  RST_N = 1'b0;
    logic                  cmd_EN = 1'b0;
    logic                  cmd_RDY;
    logic [1:0]            cmd_op = 2'b00;
    logic [WIDTH-1:0]      cmd_arg = '0;
    logic                  cfg_EN = 1'b0;
    logic                  cfg_RDY;
    logic [WIDTH-1:0]      cfg_limit = '0;
    logic [PRESCALE_W-1:0] cfg_prescale = '0;
    logic                  cfg_oneshot = 1'b0;
    logic                  count_value_RDY;
    logic                  count_value_EN = 1'b0;
    logic [WIDTH-1:0]      count_value_RV;
    logic                  tc_pulse;
    logic                  busy;

    int tests = 0;
    int failures = 0;

    counter_sequencer #(
        .WIDTH      (WIDTH),
        .PRESCALE_W (PRESCALE_W)
    ) dut (
        .CLK             (CLK),
        .RST_N           (RST_N),
        .cmd_EN          (cmd_EN),
        .cmd_RDY         (cmd_RDY),
        .cmd_op          (cmd_op),
        .cmd_arg         (cmd_arg),
        .cfg_EN          (cfg_EN),
        .cfg_RDY         (cfg_RDY),
        .cfg_limit       (cfg_limit),
        .cfg_prescale    (cfg_prescale),
        .cfg_oneshot     (cfg_oneshot),
        .count_value_RDY (count_value_RDY),
        .count_value_EN  (count_value_EN),
        .count_value_RV  (count_value_RV),
        .tc_pulse        (tc_pulse),
        .busy            (busy)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: advances once per rising edge from the inputs seen
    // at that edge, then the DUT outputs are compared 1 time unit later.
    int m_st = S_IDLE, m_cnt = 0, m_presc = 0, m_lim = MODV - 1, m_pre = 0;
    int m_one = 0, m_tc = 0;

    initial begin
        int  old_st;
        bit  take_cfg;
        forever begin
            @(posedge CLK);
            if (!RST_N) begin
                m_st = S_IDLE; m_cnt = 0; m_presc = 0;
                m_lim = MODV - 1; m_pre = 0; m_one = 0; m_tc = 0;
            end else begin
                old_st   = m_st;
                m_tc     = 0;
                take_cfg = cfg_EN && (old_st == S_IDLE || old_st == S_DONE);
                if (cmd_EN && cmd_op != C_START) begin
                    if (cmd_op == C_STOP) begin
                        if (old_st == S_RUN) m_st = S_HOLD;
                    end else if (cmd_op == C_LOAD) begin
                        m_cnt = int'(cmd_arg); m_presc = 0;
                        if (old_st == S_DONE) m_st = S_IDLE;
                    end else begin
                        m_cnt = 0; m_presc = 0; m_st = S_IDLE;
                    end
                end else begin
                    if (cmd_EN) begin
                        if (old_st == S_DONE) begin m_cnt = 0; m_presc = 0; end
                        m_st = S_RUN;
                    end
                    if (old_st == S_RUN) begin
                        if (m_presc == m_pre) begin
                            m_presc = 0;
                            if (m_cnt == m_lim) begin
                                m_tc = 1;
                                if (m_one != 0) m_st = S_DONE;
                                else m_cnt = 0;
                            end else begin
                                m_cnt = (m_cnt + 1) % MODV;
                            end
                        end else begin
                            m_presc = m_presc + 1;
                        end
                    end
                end
                if (take_cfg) begin
                    m_lim = int'(cfg_limit); m_pre = int'(cfg_prescale); m_one = int'(cfg_oneshot);
                end
            end
            #1;
            check("model_rv",      32'(count_value_RV), 32'(m_cnt));
            check("model_tc",      32'(tc_pulse),       32'(m_tc));
            check("model_busy",    32'(busy),           32'(m_st == S_RUN || m_st == S_HOLD));
            check("model_cfg_rdy", 32'(cfg_RDY),        32'(m_st == S_IDLE || m_st == S_DONE));
            check("cmd_rdy",       32'(cmd_RDY),        32'd1);
            check("rd_rdy",        32'(count_value_RDY), 32'd1);
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge CLK);
            #2;
        end
    endtask

    task automatic cmd(input logic [1:0] op, input logic [WIDTH-1:0] arg);
        cmd_EN = 1'b1; cmd_op = op; cmd_arg = arg;
        step(1);
        cmd_EN = 1'b0;
    endtask

    task automatic cfg_set(input int lim, input int pre, input int one);
        cfg_EN = 1'b1;
        cfg_limit = WIDTH'(lim); cfg_prescale = PRESCALE_W'(pre); cfg_oneshot = one[0];
    endtask

    task automatic expect_out(input string name, input int rv, input int tc);
        check({name, "_rv"}, 32'(count_value_RV), 32'(rv));
        check({name, "_tc"}, 32'(tc_pulse), 32'(tc));
    endtask

    initial begin
        int e2_rv [7] = '{1, 2, 3, 4, 5, 0, 1};
        int e2_tc [7] = '{0, 0, 0, 0, 0, 1, 0};

        // Power-on reset
        step(2);
        RST_N = 1'b1;
        expect_out("por", 0, 0);
        check("por_busy", 32'(busy), 32'd0);
        check("por_cfg_rdy", 32'(cfg_RDY), 32'd1);

        // Reset applied mid-count
        cfg_set(15, 0, 0);
        cmd(C_START, '0);
        cfg_EN = 1'b0;
        step(5);
        check("t1_pre_rst_rv", 32'(count_value_RV), 32'd5);
        RST_N = 1'b0;
        cmd_EN = 1'b1; cmd_op = C_START;
        step(2);
        cmd_EN = 1'b0;
        RST_N = 1'b1;
        expect_out("t1_rst", 0, 0);
        check("t1_busy", 32'(busy), 32'd0);
        check("t1_cfg_rdy", 32'(cfg_RDY), 32'd1);

        // Periodic, limit 5, prescale 0, config with START
        cfg_set(5, 0, 0);
        cmd(C_START, '0);
        cfg_EN = 1'b0;
        check("t2_first_rv", 32'(count_value_RV), 32'd0);
        for (int k = 0; k < 7; k++) begin
            step(1);
            expect_out($sformatf("t2_%0d", k), e2_rv[k], e2_tc[k]);
        end
        cmd(C_CLEAR, '0);
        check("t2_clr_busy", 32'(busy), 32'd0);

        // Prescale 2, full-range wrap
        cfg_set(15, 2, 0);
        cmd(C_START, '0);
        cfg_EN = 1'b0;
        step(3);
        expect_out("t3_a", 1, 0);
        step(3);
        expect_out("t3_b", 2, 0);
        step(39);
        expect_out("t3_c", 15, 0);
        step(2);
        expect_out("t3_d", 15, 0);
        step(1);
        expect_out("t3_wrap", 0, 1);
        cmd(C_CLEAR, '0);

        // One-shot, limit 3
        cfg_set(3, 0, 1);
        cmd(C_START, '0);
        cfg_EN = 1'b0;
        step(3);
        expect_out("t4_a", 3, 0);
        check("t4_a_busy", 32'(busy), 32'd1);
        step(1);
        expect_out("t4_done", 3, 1);
        check("t4_busy", 32'(busy), 32'd0);
        check("t4_cfg_rdy", 32'(cfg_RDY), 32'd1);
        step(4);
        expect_out("t4_hold", 3, 0);

        // From DONE: restart periodic limit 9, then STOP/HOLD
        cfg_set(9, 0, 0);
        cmd(C_START, '0);
        cfg_EN = 1'b0;
        check("t5_restart_rv", 32'(count_value_RV), 32'd0);
        step(2);
        cmd(C_STOP, '0);
        expect_out("t5_stop", 2, 0);
        check("t5_cfg_rdy", 32'(cfg_RDY), 32'd0);
        cfg_set(1, 0, 1);
        for (int k = 0; k < 10; k++) begin
            step(1);
            check($sformatf("t5_hold_rv_%0d", k), 32'(count_value_RV), 32'd2);
        end
        check("t5_hold_busy", 32'(busy), 32'd1);
        cfg_EN = 1'b0;
        cmd(C_START, '0);
        expect_out("t5_resume0", 2, 0);
        step(1);
        expect_out("t5_resume1", 3, 0);
        step(6);
        expect_out("t5_lim", 9, 0);
        step(1);
        expect_out("t5_wrap", 0, 1);

        // LOAD while running (load wins over tick), CLEAR, LOAD above limit
        step(2);
        cmd(C_LOAD, 4'd7);
        expect_out("t6_ld", 7, 0);
        step(1);
        expect_out("t6_8", 8, 0);
        step(1);
        expect_out("t6_9", 9, 0);
        step(1);
        expect_out("t6_0", 0, 1);
        cmd(C_CLEAR, '0);
        expect_out("t6_clr", 0, 0);
        check("t6_clr_busy", 32'(busy), 32'd0);
        cmd(C_LOAD, 4'd14);
        expect_out("t6_ld14", 14, 0);
        check("t6_ld_busy", 32'(busy), 32'd0);
        cmd(C_START, '0);
        step(1);
        expect_out("t6_15", 15, 0);
        step(1);
        expect_out("t6_over_wrap", 0, 0);
        step(1);
        expect_out("t6_1", 1, 0);

        step(2);
        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
